memory_stage: RTL and testbench

Memory stage of the 5-stage Y86-64 pipeline, directly downstream of execute. It holds the M pipeline register, fed by the execute ALU result (`e_valE`) and condition (`e_Cnd`). It performs the data-memory access over a req/ack handshake with wait-state and timeout support, then loads the W pipeline register for write-back. It also exports `m_valM`/`m_stat` for forwarding and `mem_busy` for the hazard unit.

---
 rtl/memory_stage.sv | 211 +++++++++++++++++++++
 tb/tb_memory_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Y86-64 memory stage: M pipeline register, data-memory access over a req/ack handshake with
// wait states and timeout, and the W pipeline register.
module memory_stage #(
    parameter logic [63:0] MEM_SIZE = 64'h2000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  e_stat,
    input  logic [3:0]  e_icode,
    input  logic        e_Cnd,
    input  logic [63:0] e_valE,
    input  logic [63:0] e_valA,
    input  logic [3:0]  e_dstE,
    input  logic [3:0]  e_dstM,
    input  logic        M_stall,
    input  logic        M_bubble,
    input  logic        W_stall,
    input  logic        W_bubble,
    output logic [2:0]  M_stat,
    output logic [3:0]  M_icode,
    output logic        M_Cnd,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM,
    output logic [63:0] m_valM,
    output logic [2:0]  m_stat,
    output logic        mem_busy,
    output logic [2:0]  W_stat,
    output logic [3:0]  W_icode,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM,
    output logic [3:0]  W_dstE,
    output logic [3:0]  W_dstM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [63:0] dmem_rdata,
    input  logic        dmem_err
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    localparam logic [2:0] StatBub = 3'd0;
    localparam logic [2:0] StatAok = 3'd1;
    localparam logic [2:0] StatAdr = 3'd2;

    localparam logic [3:0] INop    = 4'h1;
    localparam logic [3:0] IRmmovq = 4'h4;
    localparam logic [3:0] IMrmovq = 4'h5;
    localparam logic [3:0] ICall   = 4'h8;
    localparam logic [3:0] IRet    = 4'h9;
    localparam logic [3:0] IPushq  = 4'hA;
    localparam logic [3:0] IPopq   = 4'hB;
    localparam logic [3:0] RNone   = 4'hF;

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] count_q, count_d;
    logic [63:0]     hold_valm_q;
    logic [2:0]      hold_stat_q;

    logic        is_read, is_write, mem_op;
    logic [63:0] addr;
    logic [64:0] addr_end;
    logic        addr_ok, need_access, addr_err, timeout, complete;

    always_comb begin
        is_read     = M_icode inside {IMrmovq, IPopq, IRet};
        is_write    = M_icode inside {IRmmovq, IPushq, ICall};
        mem_op      = is_read || is_write;
        addr        = (M_icode inside {IPopq, IRet}) ? M_valA : M_valE;
        // 65-bit sum so addresses near 2^64 cannot wrap past the range check
        addr_end    = {1'b0, addr} + 65'd8;
        addr_ok     = addr_end <= {1'b0, MEM_SIZE};
        need_access = (M_stat == StatAok) && mem_op && addr_ok;
        addr_err    = (M_stat == StatAok) && mem_op && !addr_ok;
    end

    always_comb begin
        dmem_req   = (state_q == StIdle) ? need_access : (state_q == StWait);
        dmem_we    = dmem_req && is_write;
        dmem_addr  = addr;
        dmem_wdata = M_valA;
        timeout    = (state_q == StWait) && !dmem_ack && (count_q == CntLast);
        complete   = dmem_req && (dmem_ack || timeout);
        // A completion that W cannot take yet must keep M frozen as well
        mem_busy   = (dmem_req && !complete) || (complete && W_stall) ||
                     ((state_q == StDone) && W_stall);
    end

    always_comb begin
        m_valM = '0;
        m_stat = M_stat;
        if (state_q == StDone) begin
            m_valM = hold_valm_q;
            m_stat = hold_stat_q;
        end else if (addr_err) begin
            m_stat = StatAdr;
        end else if (dmem_req && dmem_ack) begin
            m_valM = is_read ? dmem_rdata : '0;
            m_stat = dmem_err ? StatAdr : M_stat;
        end else if (timeout) begin
            m_stat = StatAdr;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (need_access) begin
                    if (dmem_ack) begin
                        state_d = W_stall ? StDone : StIdle;
                    end else begin
                        state_d = StWait;
                        count_d = '0;
                    end
                end
            end
            StWait: begin
                count_d = count_q + CntW'(1);
                if (dmem_ack || timeout) state_d = W_stall ? StDone : StIdle;
            end
            StDone: begin
                if (!W_stall) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            count_q     <= '0;
            hold_valm_q <= '0;
            hold_stat_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (complete && W_stall) begin
                hold_valm_q <= m_valM;
                hold_stat_q <= m_stat;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            M_stat  <= StatBub;
            M_icode <= INop;
            M_Cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= RNone;
            M_dstM  <= RNone;
        end else if (!mem_busy && !M_stall) begin
            if (M_bubble) begin
                M_stat  <= StatBub;
                M_icode <= INop;
                M_Cnd   <= 1'b0;
                M_valE  <= '0;
                M_valA  <= '0;
                M_dstE  <= RNone;
                M_dstM  <= RNone;
            end else begin
                M_stat  <= e_stat;
                M_icode <= e_icode;
                M_Cnd   <= e_Cnd;
                M_valE  <= e_valE;
                M_valA  <= e_valA;
                M_dstE  <= e_dstE;
                M_dstM  <= e_dstM;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            W_stat  <= StatBub;
            W_icode <= INop;
            W_valE  <= '0;
            W_valM  <= '0;
            W_dstE  <= RNone;
            W_dstM  <= RNone;
        end else if (!W_stall) begin
            if (W_bubble || mem_busy) begin
                W_stat  <= StatBub;
                W_icode <= INop;
                W_valE  <= '0;
                W_valM  <= '0;
                W_dstE  <= RNone;
                W_dstM  <= RNone;
            end else begin
                W_stat  <= m_stat;
                W_icode <= M_icode;
                W_valE  <= M_valE;
                W_valM  <= m_valM;
                W_dstE  <= M_dstE;
                W_dstM  <= M_dstM;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: non-memory op, zero-wait, wait-state, range error, timeout,
// W stall during completion and reset during a pending access.
module tb_memory_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  e_stat;
    logic [3:0]  e_icode;
    logic        e_Cnd;
    logic [63:0] e_valE, e_valA;
    logic [3:0]  e_dstE, e_dstM;
    logic        M_stall, M_bubble, W_stall, W_bubble;
    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valE, M_valA;
    logic [3:0]  M_dstE, M_dstM;
    logic [63:0] m_valM;
    logic [2:0]  m_stat;
    logic        mem_busy;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE, W_valM;
    logic [3:0]  W_dstE, W_dstM;
    logic        dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic        dmem_err;

    int tests = 0;
    int fails = 0;

    memory_stage dut (
        .clock(clock), .reset(reset),
        .e_stat(e_stat), .e_icode(e_icode), .e_Cnd(e_Cnd), .e_valE(e_valE), .e_valA(e_valA),
        .e_dstE(e_dstE), .e_dstM(e_dstM),
        .M_stall(M_stall), .M_bubble(M_bubble), .W_stall(W_stall), .W_bubble(W_bubble),
        .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA),
        .M_dstE(M_dstE), .M_dstM(M_dstM),
        .m_valM(m_valM), .m_stat(m_stat), .mem_busy(mem_busy),
        .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .dmem_err(dmem_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_e(input logic [3:0] icode, input logic [63:0] vale, input logic [63:0] vala,
                          input logic [3:0] dste, input logic [3:0] dstm);
        e_stat  = 3'd1;
        e_icode = icode;
        e_valE  = vale;
        e_valA  = vala;
        e_dstE  = dste;
        e_dstM  = dstm;
    endtask

    task automatic nop_e();
        e_stat  = 3'd0;
        e_icode = 4'h1;
        e_valE  = '0;
        e_valA  = '0;
        e_dstE  = 4'hF;
        e_dstM  = 4'hF;
    endtask

    initial begin
        reset = 1'b0;
        nop_e();
        e_Cnd = 1'b0;
        M_stall = 1'b0; M_bubble = 1'b0; W_stall = 1'b0; W_bubble = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = '0; dmem_err = 1'b0;
        tick();
        tick();
        check("rst_W_stat", W_stat, 3'd0);
        check("rst_W_icode", W_icode, 4'h1);
        check("rst_W_dstE", W_dstE, 4'hF);
        check("rst_M_icode", M_icode, 4'h1);
        check("rst_M_dstM", M_dstM, 4'hF);
        check("rst_req", dmem_req, 1'b0);
        check("rst_busy", mem_busy, 1'b0);
        reset = 1'b1;

        // ADD: one edge into M, one more into W
        load_e(4'h6, 64'd5, 64'd0, 4'd3, 4'hF);
        tick();
        nop_e();
        #1;
        check("add_M_valE", M_valE, 64'd5);
        check("add_req", dmem_req, 1'b0);
        tick();
        check("add_W_valE", W_valE, 64'd5);
        check("add_W_dstE", W_dstE, 4'd3);
        check("add_W_stat", W_stat, 3'd1);
        check("add_req2", dmem_req, 1'b0);

        // MRMOVQ, zero-wait ack
        load_e(4'h5, 64'h100, 64'd0, 4'hF, 4'd2);
        tick();
        nop_e();
        dmem_ack = 1'b1; dmem_rdata = 64'hDEAD;
        #1;
        check("mr_req", dmem_req, 1'b1);
        check("mr_addr", dmem_addr, 64'h100);
        check("mr_we", dmem_we, 1'b0);
        check("mr_busy", mem_busy, 1'b0);
        tick();
        dmem_ack = 1'b0;
        check("mr_W_valM", W_valM, 64'hDEAD);
        check("mr_W_dstM", W_dstM, 4'd2);
        check("mr_W_stat", W_stat, 3'd1);

        // PUSHQ acked in the fourth request cycle
        load_e(4'hA, 64'h1F8, 64'h42, 4'd4, 4'hF);
        tick();
        nop_e();
        #1;
        for (int i = 0; i < 3; i++) begin
            check("push_req", dmem_req, 1'b1);
            check("push_we", dmem_we, 1'b1);
            check("push_wdata", dmem_wdata, 64'h42);
            check("push_addr", dmem_addr, 64'h1F8);
            check("push_busy", mem_busy, 1'b1);
            tick();
            check("push_W_bubble", W_icode, 4'h1);
        end
        dmem_ack = 1'b1;
        #1;
        check("push_req_ack", dmem_req, 1'b1);
        check("push_wdata_ack", dmem_wdata, 64'h42);
        check("push_busy_ack", mem_busy, 1'b0);
        tick();
        dmem_ack = 1'b0;
        check("push_W_icode", W_icode, 4'hA);
        check("push_W_valE", W_valE, 64'h1F8);
        check("push_W_valM", W_valM, 64'h0);
        check("push_W_stat", W_stat, 3'd1);

        // POPQ past the end of memory: no request, SADR
        load_e(4'hB, 64'h10, 64'h1FFC, 4'd4, 4'd5);
        tick();
        nop_e();
        #1;
        check("pop_req", dmem_req, 1'b0);
        check("pop_m_stat", m_stat, 3'd2);
        check("pop_busy", mem_busy, 1'b0);
        tick();
        check("pop_W_stat", W_stat, 3'd2);
        check("pop_W_icode", W_icode, 4'hB);

        // Last legal doubleword
        load_e(4'h5, 64'h1FF8, 64'd0, 4'hF, 4'd7);
        tick();
        nop_e();
        dmem_ack = 1'b1; dmem_rdata = 64'h77;
        #1;
        check("edge_req", dmem_req, 1'b1);
        check("edge_m_stat", m_stat, 3'd1);
        tick();
        dmem_ack = 1'b0;
        check("edge_W_valM", W_valM, 64'h77);

        // RMMOVQ never acked: timeout reaches W at edge TIMEOUT+1
        load_e(4'h4, 64'h200, 64'h99, 4'hF, 4'hF);
        tick();
        nop_e();
        #1;
        for (int i = 0; i < 16; i++) begin
            check("to_req", dmem_req, 1'b1);
            check("to_busy", mem_busy, 1'b1);
            tick();
        end
        check("to_req_last", dmem_req, 1'b1);
        check("to_m_stat", m_stat, 3'd2);
        check("to_busy_last", mem_busy, 1'b0);
        tick();
        check("to_W_stat", W_stat, 3'd2);
        check("to_W_icode", W_icode, 4'h4);
        check("to_req_drop", dmem_req, 1'b0);
        check("to_busy_drop", mem_busy, 1'b0);

        // MRMOVQ completes while W is stalled for two cycles
        load_e(4'h5, 64'h300, 64'd0, 4'hF, 4'd6);
        tick();
        nop_e();
        #1;
        check("ws_busy0", mem_busy, 1'b1);
        tick();
        W_stall = 1'b1; dmem_ack = 1'b1; dmem_rdata = 64'hBEEF;
        #1;
        check("ws_m_valM", m_valM, 64'hBEEF);
        check("ws_busy1", mem_busy, 1'b1);
        tick();
        dmem_ack = 1'b0; dmem_rdata = '0;
        #1;
        check("ws_req_done", dmem_req, 1'b0);
        check("ws_busy2", mem_busy, 1'b1);
        tick();
        W_stall = 1'b0;
        #1;
        check("ws_busy3", mem_busy, 1'b0);
        check("ws_held_valM", m_valM, 64'hBEEF);
        tick();
        check("ws_W_valM", W_valM, 64'hBEEF);
        check("ws_W_stat", W_stat, 3'd1);
        check("ws_W_dstM", W_dstM, 4'd6);

        // Reset during WAIT abandons the access
        load_e(4'h5, 64'h400, 64'd0, 4'hF, 4'd1);
        tick();
        nop_e();
        tick();
        check("rw_req_wait", dmem_req, 1'b1);
        reset = 1'b0;
        #1;
        check("rw_req", dmem_req, 1'b0);
        check("rw_busy", mem_busy, 1'b0);
        check("rw_M_icode", M_icode, 4'h1);
        check("rw_M_stat", M_stat, 3'd0);
        check("rw_W_icode", W_icode, 4'h1);
        dmem_ack = 1'b1; dmem_rdata = 64'h1234;
        reset = 1'b1;
        #1;
        check("rw_late_ack_req", dmem_req, 1'b0);
        tick();
        check("rw_W_stat", W_stat, 3'd0);
        check("rw_W_valM", W_valM, 64'h0);
        dmem_ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
